// File: rtl/mio_responder.sv
// Memory-mapped I/O responder: word RAM, LED register, switch input and free-running timer
// behind a req/ready handshake with a sticky unmapped-access flag.
module mio_responder #(
   parameter int RAM_AW = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   input  logic [15:0] sw_in,
   output logic [15:0] led_out,
   output logic        bus_err
);

   localparam int RAM_WORDS = 2 ** RAM_AW;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      RAM_WAIT = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_nx_s;
   logic [31:0]         addr_r;
   logic                we_r;
   logic [31:0]         wdata_r;
   logic [31:0]         timer_r;
   logic [31:0]         ram_q_r;
   logic [31:0]         ram_r [RAM_WORDS];

   logic [31:0]         word_addr_s;
   logic [31:0]         addr_hi_s;
   logic                is_ram_s;
   logic                is_led_s;
   logic                is_sw_s;
   logic                is_timer_s;
   logic                is_unmapped_s;
   logic                ram_en_s;
   logic [RAM_AW-1:0]   ram_idx_s;

   // Address decode of the latched request; byte offset bits are ignored
   always_comb begin
      word_addr_s   = {addr_r[31:2], 2'b00};
      addr_hi_s     = addr_r >> (RAM_AW + 2);
      is_ram_s      = (addr_hi_s == 32'd0);
      is_led_s      = (word_addr_s == 32'hF000_0000);
      is_sw_s       = (word_addr_s == 32'hF000_0004);
      is_timer_s    = (word_addr_s == 32'hF000_0008);
      is_unmapped_s = !(is_ram_s || is_led_s || is_sw_s || is_timer_s);
      ram_idx_s     = addr_r[RAM_AW+1:2];
      ram_en_s      = (state_r == ACCESS) && is_ram_s;
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (req) state_nx_s = ACCESS;
            else     state_nx_s = IDLE;
         end
         ACCESS: begin
            if (is_ram_s) state_nx_s = RAM_WAIT;
            else          state_nx_s = RESP;
         end
         RAM_WAIT: state_nx_s = RESP;
         RESP:     state_nx_s = IDLE;
         default:  state_nx_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_nx_s;
   end

   // Request latch, register file, timer and registered response outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_r  <= 32'd0;
         we_r    <= 1'b0;
         wdata_r <= 32'd0;
         rdata   <= 32'd0;
         ready   <= 1'b0;
         led_out <= 16'd0;
         timer_r <= 32'd0;
         bus_err <= 1'b0;
      end else begin
         ready   <= (state_nx_s == RESP);
         timer_r <= timer_r + 32'd1;
         rdata   <= 32'd0;
         case (state_r)
            IDLE: begin
               if (req) begin
                  addr_r  <= addr;
                  we_r    <= we;
                  wdata_r <= wdata;
               end
            end
            ACCESS: begin
               if (is_led_s) begin
                  if (we_r) led_out <= wdata_r[15:0];
                  else      rdata   <= {16'd0, led_out};
               end else if (is_sw_s) begin
                  if (!we_r) rdata <= {16'd0, sw_in};
               end else if (is_timer_s) begin
                  // a write replaces this edge's increment; a read sees the pre-edge value
                  if (we_r) timer_r <= wdata_r;
                  else      rdata   <= timer_r;
               end else if (is_unmapped_s) begin
                  bus_err <= 1'b1;
               end
            end
            RAM_WAIT: begin
               if (!we_r) rdata <= ram_q_r;
            end
            RESP:    rdata <= 32'd0;
            default: rdata <= 32'd0;
         endcase
      end
   end

   // RAM array: no reset, so contents survive reset and an issued write always lands
   always_ff @(posedge clk) begin
      if (ram_en_s) begin
         if (we_r) ram_r[ram_idx_s] <= wdata_r;
         ram_q_r <= ram_r[ram_idx_s];
      end
   end

endmodule

// File: tb/tb_mio_responder.sv
// Randomised self-checking bench for mio_responder against a map-level model
// (sparse RAM array, LED/flag variables, timer as offset plus cycles since reset).
module tb_mio_responder;

   localparam logic [31:0] RAM_BYTES = 32'd1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic [15:0] sw_in;
   logic [15:0] led_out;
   logic        bus_err;

   int          checks = 0;
   int          errors = 0;

   logic [31:0] edge_cnt;
   logic [31:0] acc_cnt;
   logic [31:0] mem_m [int];
   logic [15:0] led_m;
   logic        berr_m;
   logic [31:0] toff;

   mio_responder dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .ready   (ready),
      .sw_in   (sw_in),
      .led_out (led_out),
      .bus_err (bus_err)
   );

   always #5 clk = ~clk;

   // Cycles since reset release: the timer value before the next edge is toff + edge_cnt
   always @(posedge clk or posedge reset) begin
      if (reset) edge_cnt <= 32'd0;
      else       edge_cnt <= edge_cnt + 32'd1;
   end

   // One CPU transaction, called at a negedge; one turnaround cycle first, inputs scrambled after sampling
   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input bit b2b,
                       output logic [31:0] rd, output int lat, output bit idle_bad);
      rd = 32'd0; lat = 0; idle_bad = 1'b0;
      if (b2b) begin req = 1'b1; we = w; addr = a; wdata = d; end
      @(negedge clk);
      if (ready !== 1'b0 || rdata !== 32'd0) idle_bad = 1'b1;
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk); #1;
      we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 1) acc_cnt = edge_cnt;
         if (ready === 1'b1) begin lat = n; rd = rdata; break; end
         if (rdata !== 32'd0) idle_bad = 1'b1;
      end
      req = 1'b0;
   endtask

   // Drives a RAM access and asserts reset just after the ACCESS edge (controller in RAM_WAIT)
   task automatic abort_in_ram_wait(input logic w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1; req = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] rd; int lat; bit ib;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", ready); end
      checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h expected 0", rdata); end
      checks++; if (led_out !== 16'd0) begin errors++; $display("FAIL reset_led got %h expected 0", led_out); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b expected 0", bus_err); end
      reset = 1'b0; led_m = 16'd0; berr_m = 1'b0; toff = 32'd0;
      xact(1'b0, 32'hF000_0008, 32'd0, 1'b0, rd, lat, ib);
      checks++; if (rd !== toff + acc_cnt) begin errors++; $display("FAIL reset_timer got %h expected %h", rd, toff + acc_cnt); end
   endtask

   task automatic test_ram;
      logic [31:0] rd; int lat; bit ib;
      xact(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, rd, lat, ib);
      mem_m[4] = 32'h1234_5678;
      checks++; if (lat !== 3) begin errors++; $display("FAIL ram_wr_latency got %0d expected 3", lat); end
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL ram_wr_rdata got %h expected 0", rd); end
      xact(1'b0, 32'h0000_0010, 32'd0, 1'b0, rd, lat, ib);
      checks++; if (lat !== 3) begin errors++; $display("FAIL ram_rd_latency got %0d expected 3", lat); end
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ram_rd_data got %h expected 12345678", rd); end
      checks++; if (ib !== 1'b0) begin errors++; $display("FAIL ram_idle_rdata got %b expected 0", ib); end
   endtask

   task automatic test_led;
      logic [31:0] rd; int lat; bit ib;
      xact(1'b1, 32'hF000_0000, 32'h0000_A5A5, 1'b0, rd, lat, ib);
      led_m = 16'hA5A5;
      checks++; if (led_out !== 16'hA5A5) begin errors++; $display("FAIL led_out got %h expected a5a5", led_out); end
      xact(1'b0, 32'hF000_0002, 32'd0, 1'b1, rd, lat, ib);
      checks++; if (lat !== 2) begin errors++; $display("FAIL led_rd_latency got %0d expected 2", lat); end
      checks++; if (rd !== 32'h0000_A5A5) begin errors++; $display("FAIL led_rd_data got %h expected 0000a5a5", rd); end
   endtask

   task automatic test_sw;
      logic [31:0] rd; int lat; bit ib;
      sw_in = 16'h00FF;
      xact(1'b0, 32'hF000_0004, 32'd0, 1'b0, rd, lat, ib);
      checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL sw_rd got %h expected 000000ff", rd); end
      xact(1'b1, 32'hF000_0004, 32'hDEAD_BEEF, 1'b1, rd, lat, ib);
      xact(1'b0, 32'hF000_0004, 32'd0, 1'b1, rd, lat, ib);
      checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL sw_after_write got %h expected 000000ff", rd); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL sw_write_bus_err got %b expected 0", bus_err); end
   endtask

   task automatic test_timer;
      logic [31:0] rd; int lat; bit ib;
      xact(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, 1'b0, rd, lat, ib);
      toff = 32'hFFFF_FFFE - (acc_cnt + 32'd1);
      xact(1'b0, 32'hF000_0008, 32'd0, 1'b1, rd, lat, ib);
      checks++; if (rd !== toff + acc_cnt) begin errors++; $display("FAIL timer_wrap got %h expected %h", rd, toff + acc_cnt); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL timer_latency got %0d expected 2", lat); end
      repeat (5) @(negedge clk);
      xact(1'b0, 32'hF000_0008, 32'd0, 1'b0, rd, lat, ib);
      checks++; if (rd !== toff + acc_cnt) begin errors++; $display("FAIL timer_later got %h expected %h", rd, toff + acc_cnt); end
   endtask

   task automatic test_unmapped;
      logic [31:0] rd; int lat; bit ib;
      xact(1'b0, 32'h8000_0000, 32'd0, 1'b0, rd, lat, ib);
      berr_m = 1'b1;
      checks++; if (lat !== 2) begin errors++; $display("FAIL unmapped_latency got %0d expected 2", lat); end
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_rdata got %h expected 0", rd); end
      checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL unmapped_bus_err got %b expected 1", bus_err); end
      xact(1'b1, 32'hF000_000C, 32'h0000_1111, 1'b0, rd, lat, ib);
      checks++; if (led_out !== led_m) begin errors++; $display("FAIL unmapped_wr_led got %h expected %h", led_out, led_m); end
      xact(1'b1, RAM_BYTES - 32'd4, 32'h0BAD_F00D, 1'b0, rd, lat, ib);
      mem_m[255] = 32'h0BAD_F00D;
      checks++; if (lat !== 3) begin errors++; $display("FAIL ram_top_latency got %0d expected 3", lat); end
      xact(1'b0, RAM_BYTES, 32'd0, 1'b0, rd, lat, ib);
      checks++; if (lat !== 2 || rd !== 32'd0) begin errors++; $display("FAIL ram_edge_unmapped got lat %0d data %h expected 2/0", lat, rd); end
      xact(1'b0, RAM_BYTES - 32'd4, 32'd0, 1'b0, rd, lat, ib);
      checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL ram_top_rd got %h expected 0badf00d", rd); end
      checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_sticky got %b expected 1", bus_err); end
   endtask

   task automatic test_reset_midflight;
      logic [31:0] rd; int lat; bit ib;
      abort_in_ram_wait(1'b1, 32'h0000_0020, 32'hCAFE_F00D);
      mem_m[8] = 32'hCAFE_F00D;
      @(negedge clk); reset = 1'b0;
      abort_in_ram_wait(1'b0, 32'h0000_0010, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b expected 0", ready); end
      end
      checks++; if (led_out !== 16'd0) begin errors++; $display("FAIL abort_led got %h expected 0", led_out); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL abort_bus_err got %b expected 0", bus_err); end
      reset = 1'b0; led_m = 16'd0; berr_m = 1'b0; toff = 32'd0;
      xact(1'b0, 32'hF000_0008, 32'd0, 1'b0, rd, lat, ib);
      checks++; if (rd !== toff + acc_cnt) begin errors++; $display("FAIL abort_timer got %h expected %h", rd, toff + acc_cnt); end
      checks++; if (ib !== 1'b0) begin errors++; $display("FAIL abort_spurious_ready got %b expected 0", ib); end
      xact(1'b0, 32'h0000_0010, 32'd0, 1'b0, rd, lat, ib);
      checks++; if (rd !== mem_m[4]) begin errors++; $display("FAIL abort_ram_kept got %h expected %h", rd, mem_m[4]); end
      xact(1'b0, 32'h0000_0020, 32'd0, 1'b1, rd, lat, ib);
      checks++; if (rd !== mem_m[8]) begin errors++; $display("FAIL abort_ram_write_done got %h expected %h", rd, mem_m[8]); end
   endtask

   task automatic test_random;
      logic [31:0] rd, a, d, exp_rd; int lat, kind, idx, exp_lat; bit ib, b2b; logic w;
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 4);
         w    = 1'($urandom_range(0, 1));
         b2b  = 1'($urandom_range(0, 1));
         d    = $urandom;
         idx  = 0;
         a    = 32'($urandom_range(0, 3));
         sw_in = 16'($urandom);
         case (kind)
            0: begin
               idx = $urandom_range(0, 15);
               if (!w && !mem_m.exists(idx)) w = 1'b1;
               a = a + 32'(idx * 4);
            end
            1: a = a + 32'hF000_0000;
            2: a = a + 32'hF000_0004;
            3: a = a + 32'hF000_0008;
            default: begin
               a = $urandom | 32'h8000_0000;
               if (a >= 32'hF000_0000 && a < 32'hF000_000C) a = 32'h9000_0000;
            end
         endcase
         xact(w, a, d, b2b, rd, lat, ib);
         exp_lat = (kind == 0) ? 3 : 2;
         exp_rd  = 32'd0;
         case (kind)
            0: if (w) mem_m[idx] = d; else exp_rd = mem_m[idx];
            1: if (w) led_m = d[15:0]; else exp_rd = {16'd0, led_m};
            2: if (!w) exp_rd = {16'd0, sw_in};
            3: if (w) toff = d - (acc_cnt + 32'd1); else exp_rd = toff + acc_cnt;
            default: berr_m = 1'b1;
         endcase
         checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_latency #%0d addr %h got %0d expected %0d", i, a, lat, exp_lat); end
         checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata #%0d addr %h we %b got %h expected %h", i, a, w, rd, exp_rd); end
         checks++; if (ib !== 1'b0) begin errors++; $display("FAIL rnd_idle_outputs #%0d got %b expected 0", i, ib); end
         checks++; if (led_out !== led_m) begin errors++; $display("FAIL rnd_led #%0d got %h expected %h", i, led_out, led_m); end
         checks++; if (bus_err !== berr_m) begin errors++; $display("FAIL rnd_bus_err #%0d got %b expected %b", i, bus_err, berr_m); end
      end
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; sw_in = 16'd0;
      led_m = 16'd0; berr_m = 1'b0; toff = 32'd0; acc_cnt = 32'd0;
      test_reset;
      test_ram;
      test_led;
      test_sw;
      test_timer;
      test_unmapped;
      test_reset_midflight;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
